ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), using the PS/2 request-to-send sequence. It drives both open-drain bus lines, counts device-generated clock edges, supplies odd parity and checks the device acknowledge. It sits beside the PS/2 receive path and raises `rx_inhibit` so the receiver ignores its own transmission.

## Interface
- `INHIBIT_CYCLES`, default 10000: clk cycles the PS/2 clock line is held low before request-to-send (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum clk cycles from clock release to acknowledge complete (20 ms).
- `FILTER_LEN`, default 4: consecutive equal synchronized samples required before the filtered PS/2 clock changes.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to send. Sampled only on an accepted `tx_start`.
- `tx_start` in 1: single-cycle request. Ignored while `tx_busy`=1.
- `ps2_clk_in` in 1: raw PS/2 clock pin level. Asynchronous.
- `ps2_data_in` in 1: raw PS/2 data pin level. Asynchronous.
- `ps2_clk_oe` out 1: 1 pulls the PS/2 clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the PS/2 data line low; 0 releases it.
- `tx_busy` out 1: high from the cycle after an accepted start until the cycle `tx_done` or `tx_err` pulses.
- `tx_done` out 1: one-cycle pulse when the byte is acknowledged.
- `tx_err` out 1: one-cycle pulse on timeout or missing acknowledge.
- `rx_inhibit` out 1: equals `tx_busy`. Gates the receive path.

## Operation
- Input conditioning: each raw pin goes through a 2-FF synchronizer.
- Clock filter: the filtered clock takes the synchronized value after `FILTER_LEN` equal consecutive samples.
- `fall`: one-cycle pulse on a filtered clock 1→0 transition.
- Data sampling: `ps2_data_in` is read through its synchronizer only.
- Odd parity: parity bit = ~^tx_data (set when tx_data has an even number of ones).
- States:
  - IDLE: both `_oe`=0. On `tx_start`, latch tx_data and parity, load the counter with `INHIBIT_CYCLES`, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1. On the final counter cycle, also set `ps2_data_oe`=1. Then go to RTS.
  - RTS: `ps2_clk_oe`=0, `ps2_data_oe`=1 (start bit). Clear the timeout counter and the bit index. Go to SHIFT.
  - SHIFT: on each `fall`, the index increments (1..10):
    - Falls 1–8: `ps2_data_oe` = ~bit[index-1], LSB first.
    - Fall 9: `ps2_data_oe` = ~parity.
    - Fall 10: `ps2_data_oe`=0 (stop bit; line released). Go to ACK.
  - ACK: on the next `fall`, sample data:
    - Data 0: go to WAIT_IDLE.
    - Data 1: go to ERR.
  - WAIT_IDLE: when the filtered clock is 1 and data is 1, go to DONE.
  - DONE: `tx_done`=1 for one cycle, then IDLE.
  - ERR: both `_oe`=0, `tx_err`=1 for one cycle, then IDLE.
- Timeout: counts every cycle in SHIFT, ACK and WAIT_IDLE. Reaching `TIMEOUT_CYCLES` forces ERR from any of these states.
- Data lines change only on `fall` (data changes while the clock is low). The device samples on the rising edge.
- Simultaneous events: timeout expiry has priority over a `fall` in the same cycle.
- A `tx_start` arriving in the DONE or ERR cycle is ignored.

## Timing
- Reset: all outputs 0 and both lines released. State IDLE, counters 0, latched byte 0x00.
- Reset asserted mid-transfer: the next edge releases both lines. No `tx_done` or `tx_err` is issued.
- `tx_start` accepted at edge N: `tx_busy`=1 and `ps2_clk_oe`=1 from N+1.
- `ps2_clk_oe` stays high for exactly `INHIBIT_CYCLES` cycles.
- `ps2_data_oe` rises on the last inhibit cycle and overlaps `ps2_clk_oe` by 1 cycle.
- Data update: the new `ps2_data_oe` value appears 1 cycle after the `fall` pulse. Pin-to-`oe` latency is 2 (sync) + `FILTER_LEN` + 1 cycles.
- `tx_done`/`tx_err` is asserted in the same cycle `tx_busy` falls. A new `tx_start` is accepted the following cycle.
- Minimum idle spacing between transfers: 1 cycle.

## Test plan
Bench parameters: `INHIBIT_CYCLES`=20, `TIMEOUT_CYCLES`=3000, `FILTER_LEN`=2. The device model clocks at a 100-cycle period and acks on the 11th falling edge.
- Send 0xED → the model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Ack low → single `tx_done` pulse, `tx_err`=0.
- Send 0x07 → parity 0. Check that `ps2_clk_oe` is high exactly 20 cycles and overlaps `ps2_data_oe` by exactly 1 cycle.
- Model withholds the ack (data stays 1 on the 11th fall) → `tx_err` pulse, both `_oe`=0, `tx_busy`=0.
- Model never clocks after RTS → `tx_err` exactly 3000 cycles after entering SHIFT, lines released.
- Glitch test: inject 1-cycle low glitches on `ps2_clk_in` during SHIFT → no extra bit shifted, byte 0xFF still received with parity 1.
- Assert `reset` at fall 5 of 0xAA → both `_oe`=0 and `tx_busy`=0 on the next edge, no pulses. A second `tx_start` with 0xF4 then completes with `tx_done`.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, device-clocked bit shifting,
// odd parity and acknowledge check, with a glitch-filtered view of the PS/2 clock.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    // Two-flop synchronizers; bit 0 is the clock pin, bit 1 the data pin.
    // They reset to 1 so an idle bus never looks like an edge after reset.
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;

    assign pin_raw = {ps2_data_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic s1_q;
        logic s2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q <= 1'b1;
                s2_q <= 1'b1;
            end else begin
                s1_q <= pin_raw[gi];
                s2_q <= s1_q;
            end
        end

        assign pin_sync[gi] = s2_q;
    end

    logic clk_s;
    logic data_s;

    assign clk_s  = pin_sync[0];
    assign data_s = pin_sync[1];

    logic             filt_q;
    logic             filt_prev_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                filt_q    <= clk_s;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FLT_ONE;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             data_oe_q, data_oe_d;
    logic             timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            inh_q     <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign timeout = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        par_d     = par_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    byte_d  = tx_data;
                    par_d   = ~^tx_data;
                    inh_d   = INH_LOAD;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q - INH_ONE;
                if (inh_q <= INH_ONE) begin
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end
            end
            S_RTS: begin
                tmo_d   = '0;
                idx_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                tmo_d = tmo_q + TMO_ONE;
                // Timeout wins over a coincident clock fall.
                if (timeout) begin
                    state_d = S_ERR;
                end else if (fall) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q < 4'd8) begin
                        data_oe_d = ~byte_q[idx_q[2:0]];
                    end else if (idx_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                tmo_d = tmo_q + TMO_ONE;
                if (timeout) begin
                    state_d = S_ERR;
                end else if (fall) begin
                    state_d = data_s ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                tmo_d = tmo_q + TMO_ONE;
                if (timeout) begin
                    state_d = S_ERR;
                end else if (filt_q && data_s) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR) begin
            data_oe_d = 1'b0;
        end
    end

    // Data is pulled low already in the final inhibit cycle, one cycle before RTS.
    assign ps2_data_oe = data_oe_q | ((state_q == S_INHIBIT) && (inh_q <= INH_ONE));
    assign ps2_clk_oe  = (state_q == S_INHIBIT);
    assign tx_busy     = (state_q == S_INHIBIT) || (state_q == S_RTS) || (state_q == S_SHIFT)
                      || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign tx_done     = (state_q == S_DONE);
    assign tx_err      = (state_q == S_ERR);
    assign rx_inhibit  = tx_busy;

endmodule
